// File: rtl/pwm_pkg.sv
// Shared defaults for the duty-cycle / clock-divider generator.
// Reset state is a divide-by-2 square wave on every channel.
package pwm_pkg;
  localparam int CNT_W_DEF  = 8;
  localparam int NUM_CH_DEF = 2;
  localparam int PERIOD_RST = 1;
  localparam int DUTY_RST   = 1;
endpackage

// File: rtl/pwm_duty_ch.sv
// One duty channel: holds its duty register and the registered compare output.
// The compare uses the duty that is valid after this edge, so an apply is seamless.
module pwm_duty_ch
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             apply,
  input  logic [CNT_W-1:0] shadow_duty,
  input  logic [CNT_W-1:0] cnt_nxt,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_nxt;

  assign duty_nxt = apply ? shadow_duty : duty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= CNT_W'(DUTY_RST);
      pwm    <= 1'b0;
    end else begin
      if (apply) duty_q <= shadow_duty;
      // Output holds while frozen unless a pending config lands on this edge
      if (en || apply) pwm <= (cnt_nxt < duty_nxt);
    end
  end

endmodule

// File: rtl/pwm_duty_gen.sv
// Multi-channel PWM: one shared period counter, per-channel duty compare,
// and a shadow config that is only applied at a period boundary.
module pwm_duty_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic [CNT_W-1:0]        cnt
);

  logic [CNT_W-1:0]             period_q;
  logic [CNT_W-1:0]             sh_period;
  logic [NUM_CH-1:0][CNT_W-1:0] sh_duty;
  logic                         pending;
  logic                         wrap;
  logic                         apply;
  logic                         xfer;
  logic [CNT_W-1:0]             cnt_nxt;

  assign cfg_ready = ~pending;
  assign wrap      = (cnt == period_q);
  assign xfer      = cfg_valid & ~pending;
  // pending can only be set by an earlier edge, so a same-edge transfer never applies
  assign apply     = pending & (~en | wrap);

  always_comb begin
    cnt_nxt = cnt;
    if (apply || (en && wrap)) cnt_nxt = '0;
    else if (en)               cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      period_q    <= CNT_W'(PERIOD_RST);
      sh_period   <= '0;
      sh_duty     <= '0;
      pending     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      period_tick <= en & wrap;
      if (apply) begin
        period_q <= sh_period;
        pending  <= 1'b0;
      end
      if (xfer) begin
        sh_period <= cfg_period;
        sh_duty   <= cfg_duty;
        pending   <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_duty_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .apply      (apply),
      .shadow_duty(sh_duty[i]),
      .cnt_nxt    (cnt_nxt),
      .pwm        (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Self-checking bench for pwm_duty_gen: fixed vectors, directed corner sequences,
// and random traffic against an arithmetic reference model.
module tb_pwm_duty_gen;
  localparam int CW = 8;
  localparam int NC = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_period = '0;
  logic [NC*CW-1:0] cfg_duty = '0;
  logic [NC-1:0]  pwm_out;
  logic           period_tick;
  logic [CW-1:0]  cnt;

  always #5 clk = ~clk;

  pwm_duty_gen #(.CNT_W(CW), .NUM_CH(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .cnt        (cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: counter as modular arithmetic, outputs from the invariants
  int unsigned m_cnt = 0, m_per = 1, m_sper = 0;
  int unsigned m_duty[NC];
  int unsigned m_sduty[NC];
  bit m_pend = 0, m_tick = 0, m_upd = 0;

  typedef struct {
    bit             r, e, v;
    logic [CW-1:0]  p;
    logic [NC*CW-1:0] d;
    logic [CW-1:0]  x_cnt;
    logic [NC-1:0]  x_pwm;
    bit             x_tick, x_rdy;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit xfer;
    xfer = cfg_valid && !m_pend;
    if (rst) begin
      m_cnt = 0; m_per = 1; m_pend = 0; m_tick = 0; m_upd = 0;
      for (int i = 0; i < NC; i++) m_duty[i] = 1;
    end else begin
      if (m_pend && (!en || m_cnt == m_per)) begin
        m_per = m_sper; m_duty = m_sduty; m_pend = 0;
        m_cnt = 0; m_tick = en; m_upd = 1;
      end else if (en) begin
        m_cnt  = (m_cnt + 1) % (m_per + 1);
        m_tick = (m_cnt == 0);
        m_upd  = 1;
      end else begin
        m_tick = 0;
      end
      if (xfer) begin
        m_sper = cfg_period;
        for (int i = 0; i < NC; i++) m_sduty[i] = cfg_duty[i*CW +: CW];
        m_pend = 1;
      end
    end
  endtask

  task automatic mchk();
    logic [NC-1:0] xp;
    for (int i = 0; i < NC; i++) xp[i] = m_upd && (m_cnt < m_duty[i]);
    chk("m_cnt",   32'(cnt),         m_cnt);
    chk("m_tick",  32'(period_tick), 32'(m_tick));
    chk("m_ready", 32'(cfg_ready),   32'(!m_pend));
    chk("m_pwm",   32'(pwm_out),     32'(xp));
  endtask

  task automatic cyc(input bit r, input bit e, input bit v,
                     input logic [CW-1:0] p, input logic [NC*CW-1:0] d);
    rst = r; en = e; cfg_valid = v; cfg_period = p; cfg_duty = d;
    @(posedge clk);
    model_edge();
    #1;
    mchk();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(0, 1, 0, '0, '0);
  endtask

  task automatic wait_apply(input string nm);
    for (int k = 0; k < 300 && m_pend; k++) cyc(0, 1, 0, '0, '0);
    chk(nm, 32'(cfg_ready), 1);
  endtask

  task automatic run_to(input int unsigned c, input string nm);
    for (int k = 0; k < 300 && m_cnt != c; k++) cyc(0, 1, 0, '0, '0);
    chk(nm, 32'(cnt), c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] s_cnt;
    logic [NC-1:0] s_pwm;
    int h0, h1, tk;
    for (int i = 0; i < NC; i++) begin m_duty[i] = 1; m_sduty[i] = 0; end

    // Reset, div-2 default, then period 9 / duty {7,3} applied at the next wrap
    tbl[0] = '{1, 0, 0, 0, 0,        0, 2'b00, 0, 1};
    tbl[1] = '{0, 1, 0, 0, 0,        1, 2'b00, 0, 1};
    tbl[2] = '{0, 1, 0, 0, 0,        0, 2'b11, 1, 1};
    tbl[3] = '{0, 1, 0, 0, 0,        1, 2'b00, 0, 1};
    tbl[4] = '{0, 1, 0, 0, 0,        0, 2'b11, 1, 1};
    tbl[5] = '{0, 1, 1, 9, 16'h0703, 1, 2'b00, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0,        0, 2'b11, 1, 1};
    tbl[7] = '{0, 1, 0, 0, 0,        1, 2'b11, 0, 1};
    tbl[8] = '{0, 1, 0, 0, 0,        2, 2'b11, 0, 1};
    tbl[9] = '{0, 1, 0, 0, 0,        3, 2'b10, 0, 1};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].p, tbl[i].d);
      chk($sformatf("v%0d_cnt", i),   32'(cnt),         32'(tbl[i].x_cnt));
      chk($sformatf("v%0d_pwm", i),   32'(pwm_out),     32'(tbl[i].x_pwm));
      chk($sformatf("v%0d_tick", i),  32'(period_tick), 32'(tbl[i].x_tick));
      chk($sformatf("v%0d_ready", i), 32'(cfg_ready),   32'(tbl[i].x_rdy));
    end

    // Any 10 consecutive cycles of a 10-cycle period: 3 / 7 highs, one tick
    h0 = 0; h1 = 0; tk = 0;
    for (int k = 0; k < 10; k++) begin
      run(1);
      h0 += pwm_out[0]; h1 += pwm_out[1]; tk += period_tick;
    end
    chk("p10_high0", h0, 3);
    chk("p10_high1", h1, 7);
    chk("p10_ticks", tk, 1);

    // Mid-period transfer; second offer refused while pending
    run_to(4, "mid_reach4");
    cyc(0, 1, 1, 5, {8'd4, 8'd2});
    chk("mid_ready0", 32'(cfg_ready), 0);
    chk("mid_oldcnt", 32'(cnt), 5);
    cyc(0, 1, 1, 2, 16'h0101);
    chk("mid_second_ready", 32'(cfg_ready), 0);
    wait_apply("mid_applied");
    chk("mid_apply_cnt", 32'(cnt), 0);
    chk("mid_apply_pwm", 32'(pwm_out), 2'b11);
    run(6);
    chk("mid_p6_cnt", 32'(cnt), 0);
    chk("mid_p6_tick", 32'(period_tick), 1);

    // Transfer on the wrap edge waits one full old period
    run_to(5, "wrap_reach5");
    cyc(0, 1, 1, 3, {8'd2, 8'd1});
    chk("wrap_cnt0", 32'(cnt), 0);
    chk("wrap_ready0", 32'(cfg_ready), 0);
    run(5);
    chk("wrap_oldper_cnt", 32'(cnt), 5);
    chk("wrap_still_pend", 32'(cfg_ready), 0);
    run(1);
    chk("wrap_apply_cnt", 32'(cnt), 0);
    chk("wrap_apply_ready", 32'(cfg_ready), 1);
    run(4);
    chk("wrap_newper_cnt", 32'(cnt), 0);

    // Duty extremes, then period 0
    cyc(0, 1, 1, 9, {8'd200, 8'd0});
    wait_apply("ext_applied");
    for (int k = 0; k < 10; k++) begin
      run(1);
      chk("ext_ch0_low", 32'(pwm_out[0]), 0);
      chk("ext_ch1_high", 32'(pwm_out[1]), 1);
    end
    cyc(0, 1, 1, 0, 16'h0101);
    wait_apply("p0_applied");
    for (int k = 0; k < 5; k++) begin
      run(1);
      chk("p0_tick", 32'(period_tick), 1);
      chk("p0_cnt", 32'(cnt), 0);
    end

    // Freeze with en=0, apply while frozen, reset drops a pending config
    cyc(0, 1, 1, 9, {8'd7, 8'd3});
    wait_apply("frz_applied");
    run_to(5, "frz_reach5");
    s_cnt = cnt; s_pwm = pwm_out;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, '0, '0);
      chk("frz_cnt", 32'(cnt), 32'(s_cnt));
      chk("frz_pwm", 32'(pwm_out), 32'(s_pwm));
      chk("frz_tick", 32'(period_tick), 0);
    end
    cyc(0, 0, 1, 4, {8'd2, 8'd2});
    chk("frz_xfer_cnt", 32'(cnt), 32'(s_cnt));
    chk("frz_xfer_ready", 32'(cfg_ready), 0);
    cyc(0, 0, 0, '0, '0);
    chk("frz_apply_cnt", 32'(cnt), 0);
    chk("frz_apply_pwm", 32'(pwm_out), 2'b11);
    chk("frz_apply_tick", 32'(period_tick), 0);
    chk("frz_apply_ready", 32'(cfg_ready), 1);
    cyc(0, 1, 1, 7, {8'd5, 8'd5});
    chk("rst_pend_ready", 32'(cfg_ready), 0);
    cyc(1, 1, 0, '0, '0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_tick", 32'(period_tick), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    run(3);
    chk("rst_div2_cnt", 32'(cnt), 1);
    run(1);
    chk("rst_div2_wrap", 32'(cnt), 0);
    chk("rst_div2_pwm", 32'(pwm_out), 2'b11);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 100) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0,
          CW'($urandom % 12), {CW'($urandom % 16), CW'($urandom % 16)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
